// File: rtl/regfile_port_master.sv
// regfile_port_master: initiator for one read/write port of a multi-port
// register file; one instance per port.
//
// Requests arrive on a valid/ready handshake and are latched in IDLE. For
// exactly one ISSUE cycle the block drives the one-hot select, the write
// strobe and the write data. It then presents one response in RESP until
// that response is consumed.
//
// Ports:
//   clk_i, reset_n_i              clock, async active-low reset
//   req_valid_i/req_ready_o       request handshake
//   req_write_i, req_addr_i,
//   req_data_i                    request fields (1 = write)
//   resp_valid_o/resp_ready_i     response handshake
//   resp_data_o                   read data (0 for writes)
//   resp_err_o                    out-of-range address (macro only)
//   rf_sel_o, rf_we_o, rf_wdata_o register file drive (ISSUE only)
//   rf_rdata_i                    per-register words, zero unless selected
//   txn_count_o                   completed transactions (wraps)
//
// Optional feature: define REGFILE_PORT_MASTER_BOUNDS_CHECK_EN to add the
// resp_err_o port. Without the macro, out-of-range requests complete
// silently as no-ops.
module regfile_port_master #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 3,
  parameter int ADDR_WIDTH    = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic                              req_write_i,
  input  logic [ADDR_WIDTH-1:0]             req_addr_i,
  input  logic [DATA_WIDTH-1:0]             req_data_i,
  output logic                              resp_valid_o,
  input  logic                              resp_ready_i,
  output logic [DATA_WIDTH-1:0]             resp_data_o,
`ifdef REGFILE_PORT_MASTER_BOUNDS_CHECK_EN
  output logic                              resp_err_o,
`endif
  output logic [NUM_REGISTERS-1:0]          rf_sel_o,
  output logic                              rf_we_o,
  output logic [DATA_WIDTH-1:0]             rf_wdata_o,
  input  logic [NUM_REGISTERS*DATA_WIDTH-1:0] rf_rdata_i,
  output logic [CNT_WIDTH-1:0]              txn_count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic                     ready_en_q;
  logic                     wr_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [DATA_WIDTH-1:0]    resp_data_q;
  logic [CNT_WIDTH-1:0]     cnt_q;
  logic [NUM_REGISTERS-1:0] sel;
  logic                     in_range;
  logic [DATA_WIDTH-1:0]    rd_or;
  logic                     req_fire;
  logic                     resp_fire;

  // Out-of-range addresses match no select bit, so an empty select
  // doubles as the out-of-range flag.
  for (genvar i = 0; i < NUM_REGISTERS; i++) begin : g_sel
    assign sel[i] = (addr_q == ADDR_WIDTH'(i));
  end

  assign in_range = |sel;

  // Unselected words are zero, so OR-ing all of them yields the
  // selected word (or 0 when nothing is selected).
  always_comb begin
    rd_or = '0;
    for (int i = 0; i < NUM_REGISTERS; i++) begin
      rd_or |= rf_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign req_fire  = req_ready_o & req_valid_i;
  assign resp_fire = resp_valid_o & resp_ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    rf_sel_o     = '0;
    rf_we_o      = 1'b0;
    rf_wdata_o   = '0;
    unique case (state_q)
      S_IDLE: begin
        // ready_en_q keeps ready low while reset is held.
        req_ready_o = ready_en_q;
        if (req_fire) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rf_sel_o   = sel;
        rf_we_o    = wr_q & in_range;
        rf_wdata_o = data_q;
        state_d    = S_RESP;
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ready_en_q  <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (req_fire) begin
        wr_q   <= req_write_i;
        addr_q <= req_addr_i;
        data_q <= req_data_i;
      end
      if (state_q == S_ISSUE) begin
        resp_data_q <= wr_q ? '0 : rd_or;
      end else if (resp_fire) begin
        resp_data_q <= '0;
      end
      if (resp_fire) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign resp_data_o = resp_data_q;
  assign txn_count_o = cnt_q;

`ifdef REGFILE_PORT_MASTER_BOUNDS_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_q <= 1'b0;
    end else if (state_q == S_ISSUE) begin
      err_q <= ~in_range;
    end else if (resp_fire) begin
      err_q <= 1'b0;
    end
  end

  assign resp_err_o = err_q & resp_valid_o;
`endif

endmodule

// File: tb/tb_regfile_port_master.sv
// tb_regfile_port_master: scoreboard bench for regfile_port_master with a
// 3-entry register file model behind the port; counter width set to 2.
module tb_regfile_port_master;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [1:0]  req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  logic [2:0]  rf_sel_o;
  logic        rf_we_o;
  logic [31:0] rf_wdata_o;
  logic [95:0] rf_rdata_i;
  logic [1:0]  txn_count_o;

  always #5 clk_i = ~clk_i;

  regfile_port_master #(
    .DATA_WIDTH(32),
    .NUM_REGISTERS(3),
    .ADDR_WIDTH(2),
    .CNT_WIDTH(2)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_write_i(req_write_i),
    .req_addr_i(req_addr_i),
    .req_data_i(req_data_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o),
`ifdef REGFILE_PORT_MASTER_BOUNDS_CHECK_EN
    .resp_err_o(resp_err_o),
`endif
    .rf_sel_o(rf_sel_o),
    .rf_we_o(rf_we_o),
    .rf_wdata_o(rf_wdata_o),
    .rf_rdata_i(rf_rdata_i),
    .txn_count_o(txn_count_o)
  );

`ifndef REGFILE_PORT_MASTER_BOUNDS_CHECK_EN
  assign resp_err_o = 1'b0;
`endif

  // Register file behind the port: not reset by the master's reset.
  logic [31:0] file_q [3] = '{32'h0, 32'h0, 32'h0};

  always @(posedge clk_i) begin
    for (int i = 0; i < 3; i++) begin
      if (rf_we_o && rf_sel_o[i]) file_q[i] <= rf_wdata_o;
    end
  end

  always_comb begin
    rf_rdata_i = '0;
    for (int i = 0; i < 3; i++) begin
      if (rf_sel_o[i]) rf_rdata_i[i*32 +: 32] = file_q[i];
    end
  end

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [3] = '{32'h0, 32'h0, 32'h0};
  logic [1:0]  model_cnt = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic do_txn(input logic wr, input logic [1:0] addr,
                        input logic [31:0] data, input int hold);
    exp_t       e;
    exp_t       got;
    logic [2:0] exp_sel;
    int         n;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    checks++;
    if (req_ready_o !== 1'b1) begin
      $display("FAIL req_ready_timeout got=%b want=1", req_ready_o);
      failures++;
      return;
    end
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_data_i  = data;
    e.err  = (addr >= 2'd3);
    e.data = '0;
    if (!e.err) begin
      if (wr) model_mem[addr] = data;
      else e.data = model_mem[addr];
    end
    sb_q.push_back(e);
    exp_sel = e.err ? 3'b000 : (3'b001 << addr);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = '0;
    req_data_i  = '0;
    checks++;
    if (rf_sel_o !== exp_sel) begin
      $display("FAIL issue_sel got=%b want=%b", rf_sel_o, exp_sel);
      failures++;
    end
    checks++;
    if (rf_we_o !== (wr & ~e.err)) begin
      $display("FAIL issue_we got=%b want=%b", rf_we_o, wr & ~e.err);
      failures++;
    end
    checks++;
    if (rf_wdata_o !== data) begin
      $display("FAIL issue_wdata got=%h want=%h", rf_wdata_o, data);
      failures++;
    end
    checks++;
    if (req_ready_o !== 1'b0 || resp_valid_o !== 1'b0) begin
      $display("FAIL issue_hs got=%b%b want=00", req_ready_o, resp_valid_o);
      failures++;
    end
    @(posedge clk_i); #1;
    checks++;
    if (resp_valid_o !== 1'b1) begin
      $display("FAIL resp_latency got=%b want=1", resp_valid_o);
      failures++;
    end
    checks++;
    if (rf_sel_o !== 3'b0 || rf_we_o !== 1'b0 || rf_wdata_o !== 32'h0) begin
      $display("FAIL rf_idle got=%b/%b/%h want=0", rf_sel_o, rf_we_o, rf_wdata_o);
      failures++;
    end
    for (int i = 0; i < hold; i++) begin
      checks++;
      if (resp_valid_o !== 1'b1 || resp_data_o !== sb_q[0].data ||
          req_ready_o !== 1'b0 || txn_count_o !== model_cnt) begin
        $display("FAIL backpressure got=%b/%h/%b/%0d want=1/%h/0/%0d",
                 resp_valid_o, resp_data_o, req_ready_o, txn_count_o,
                 sb_q[0].data, model_cnt);
        failures++;
      end
      @(posedge clk_i); #1;
    end
    resp_ready_i = 1'b1;
    got = sb_q.pop_front();
    checks++;
    if (resp_data_o !== got.data) begin
      $display("FAIL resp_data got=%h want=%h", resp_data_o, got.data);
      failures++;
    end
`ifdef REGFILE_PORT_MASTER_BOUNDS_CHECK_EN
    checks++;
    if (resp_err_o !== got.err) begin
      $display("FAIL resp_err got=%b want=%b", resp_err_o, got.err);
      failures++;
    end
`endif
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
    model_cnt = model_cnt + 2'd1;
    checks++;
    if (txn_count_o !== model_cnt || resp_valid_o !== 1'b0) begin
      $display("FAIL txn_count got=%0d/%b want=%0d/0",
               txn_count_o, resp_valid_o, model_cnt);
      failures++;
    end
  endtask

  task automatic test_reset;
    reset_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({req_ready_o, resp_valid_o, resp_data_o, resp_err_o, rf_sel_o,
         rf_we_o, rf_wdata_o, txn_count_o} !== '0) begin
      $display("FAIL reset_outputs got=%b/%b/%h/%b/%b/%b/%h/%0d want=0",
               req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
               rf_sel_o, rf_we_o, rf_wdata_o, txn_count_o);
      failures++;
    end
    reset_n_i = 1'b1;
    model_cnt = '0;
    sb_q.delete();
    #1;
    checks++;
    if (req_ready_o !== 1'b0) begin
      $display("FAIL ready_before_edge got=%b want=0", req_ready_o);
      failures++;
    end
    @(posedge clk_i); #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      $display("FAIL ready_after_release got=%b want=1", req_ready_o);
      failures++;
    end
  endtask

  task automatic test_write_read;
    do_txn(1'b1, 2'd2, 32'hDEADBEEF, 0);
    do_txn(1'b1, 2'd0, 32'h0BADF00D, 0);
    do_txn(1'b1, 2'd1, 32'h5555AAAA, 0);
    do_txn(1'b0, 2'd2, 32'h0, 0);
    do_txn(1'b0, 2'd0, 32'h0, 0);
    do_txn(1'b0, 2'd1, 32'h0, 0);
  endtask

  task automatic test_back_pressure;
    do_txn(1'b0, 2'd2, 32'h0, 5);
    do_txn(1'b1, 2'd0, 32'hA5A5A5A5, 3);
    do_txn(1'b0, 2'd0, 32'h0, 2);
  endtask

  task automatic test_out_of_range;
    do_txn(1'b1, 2'd3, 32'hFFFFFFFF, 0);
    do_txn(1'b0, 2'd3, 32'h0, 2);
    do_txn(1'b0, 2'd0, 32'h0, 0);
    do_txn(1'b0, 2'd1, 32'h0, 0);
    do_txn(1'b0, 2'd2, 32'h0, 0);
  endtask

  task automatic test_mid_reset;
    int n;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = 2'd1;
    req_data_i  = 32'h1234;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = '0;
    req_data_i  = '0;
    checks++;
    if (rf_we_o !== 1'b1 || rf_sel_o !== 3'b010) begin
      $display("FAIL midrst_issue got=%b/%b want=1/010", rf_we_o, rf_sel_o);
      failures++;
    end
    reset_n_i = 1'b0;
    #1;
    checks++;
    if ({req_ready_o, resp_valid_o, resp_data_o, resp_err_o, rf_sel_o,
         rf_we_o, rf_wdata_o, txn_count_o} !== '0) begin
      $display("FAIL midrst_outputs got=%b/%b/%h/%b/%b/%h/%0d want=0",
               req_ready_o, resp_valid_o, resp_data_o, rf_sel_o,
               rf_we_o, rf_wdata_o, txn_count_o);
      failures++;
    end
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    model_cnt = '0;
    sb_q.delete();
    do_txn(1'b0, 2'd1, 32'h0, 0);
  endtask

  task automatic test_counter_wrap;
    logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    test_reset();
    for (int i = 0; i < 5; i++) begin
      do_txn(i[0], 2'(i % 3), 32'h100 + i, 0);
      checks++;
      if (txn_count_o !== exp_seq[i]) begin
        $display("FAIL count_wrap idx=%0d got=%0d want=%0d",
                 i, txn_count_o, exp_seq[i]);
        failures++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_pressure();
    test_out_of_range();
    test_mid_reset();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
